ps2_rx: RTL and testbench

- Consumes the debounced PS/2 clock and data lines and deserializes 11-bit PS/2 device-to-host frames: start, 8 data bits LSB first, odd parity, stop.
- Validates each frame and emits raw bytes.
- Folds 0xE0 (extended) and 0xF0 (break) prefixes into one decoded scan-code event for the downstream key-handling logic.
- Aborts stalled frames via a watchdog timeout.

---
 rtl/ps2_rx.sv | 190 +++++++++++++++++++
 tb/tb_ps2_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver and scan-code prefix decoder.
//
// Deserializes 11-bit frames (start, 8 data bits LSB first, odd parity, stop)
// from debounced, clk-synchronous PS/2 lines. It reports each good byte, and it
// folds the 0xE0 (extended) and 0xF0 (break) prefixes into one scan-code event.
// A watchdog aborts a frame that stalls between PS/2 falling edges.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2_clk, ps2_data   debounced PS/2 lines, already synchronous to clk
//   byte_valid          one-cycle pulse: rx_byte holds a correctly framed byte
//   rx_byte             last good received byte
//   code_valid          one-cycle pulse: complete scan-code event
//   code                scan code with prefixes stripped
//   code_break          event was preceded by 0xF0 (key release)
//   code_ext            event was preceded by 0xE0 (extended key)
//   err                 one-cycle pulse: frame rejected
//   err_type            01 parity, 10 framing, 11 timeout; holds last value
module ps2_rx #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       code_break,
    output logic       code_ext,
    output logic       err,
    output logic [1:0] err_type
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    state_e        state_q, state_d;
    logic          clk_q, clk_d;
    logic [7:0]    sr_q, sr_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          err_q, err_d;
    logic [1:0]    err_type_q, err_type_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic          code_valid_q, code_valid_d;
    logic [7:0]    code_q, code_d;
    logic          code_break_q, code_break_d;
    logic          code_ext_q, code_ext_d;

    logic          fall;
    logic [TW-1:0] to_inc;
    logic          tout, stop_fall, frame_err, par_err, good;

    assign fall   = clk_q & ~ps2_clk;
    assign to_inc = to_cnt_q + TW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a fall in the same cycle as the timeout wins
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fall && !ps2_data)             state_d = DATA;
            DATA:    if (fall && bit_cnt_q == 3'd7)     state_d = PARITY;
            PARITY:  if (fall)                          state_d = STOP;
            STOP:    if (fall)                          state_d = IDLE;
            default:                                    state_d = IDLE;
        endcase
        if (tout) state_d = IDLE;
    end

    // Frame-check outputs of the FSM
    always_comb begin
        // Fires on the edge where the counter becomes TIMEOUT-1
        tout      = (state_q != IDLE) && !fall && (to_inc == TO_LAST);
        stop_fall = (state_q == STOP) && fall;
        frame_err = stop_fall && !ps2_data;
        par_err   = stop_fall && ps2_data && !(^{sr_q, par_q});
        good      = stop_fall && ps2_data && (^{sr_q, par_q});
    end

    // Datapath and prefix decoder
    always_comb begin
        clk_d        = ps2_clk;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        par_d        = par_q;
        to_cnt_d     = (state_q == IDLE || fall) ? '0 : to_inc;

        if (state_q == IDLE && fall && !ps2_data) bit_cnt_d = '0;
        if (state_q == DATA && fall) begin
            sr_d      = {ps2_data, sr_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (state_q == PARITY && fall) par_d = ps2_data;

        byte_valid_d = good;
        rx_byte_d    = good ? sr_q : rx_byte_q;
        err_d        = frame_err | par_err | tout;
        if (frame_err)    err_type_d = 2'b10;
        else if (par_err) err_type_d = 2'b01;
        else if (tout)    err_type_d = 2'b11;
        else              err_type_d = err_type_q;

        // Decoder runs one cycle behind the byte pulse
        code_valid_d = 1'b0;
        code_d       = code_q;
        code_break_d = code_break_q;
        code_ext_d   = code_ext_q;
        brk_d        = brk_q;
        ext_d        = ext_q;
        if (byte_valid_q) begin
            if (rx_byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (rx_byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                code_valid_d = 1'b1;
                code_d       = rx_byte_q;
                code_break_d = brk_q;
                code_ext_d   = ext_q;
                brk_d        = 1'b0;
                ext_d        = 1'b0;
            end
        end
        // A rejected frame drops any partial prefix
        if (err_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_q        <= 1'b1;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            rx_byte_q    <= '0;
            err_q        <= 1'b0;
            err_type_q   <= '0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            code_valid_q <= 1'b0;
            code_q       <= '0;
            code_break_q <= 1'b0;
            code_ext_q   <= 1'b0;
        end else begin
            clk_q        <= clk_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            rx_byte_q    <= rx_byte_d;
            err_q        <= err_d;
            err_type_q   <= err_type_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            code_valid_q <= code_valid_d;
            code_q       <= code_d;
            code_break_q <= code_break_d;
            code_ext_q   <= code_ext_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign rx_byte    = rx_byte_q;
    assign err        = err_q;
    assign err_type   = err_type_q;
    assign code_valid = code_valid_q;
    assign code       = code_q;
    assign code_break = code_break_q;
    assign code_ext   = code_ext_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: self-checking bench for ps2_rx with TIMEOUT = 50.
module tb_ps2_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       code_valid;
    logic [7:0] code;
    logic       code_break;
    logic       code_ext;
    logic       err;
    logic [1:0] err_type;

    ps2_rx #(.TIMEOUT(50)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .code_valid (code_valid),
        .code       (code),
        .code_break (code_break),
        .code_ext   (code_ext),
        .err        (err),
        .err_type   (err_type)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par_bad;
        logic       stop_bad;
        logic [1:0] exp_err;
        logic       exp_ev;
        logic [7:0] exp_code;
        logic       exp_brk;
        logic       exp_ext;
    } vec_t;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    logic [7:0] byte_exp_q[$];
    ev_t        code_exp_q[$];
    logic [1:0] err_exp_q[$];

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned fall_cyc = 0;
    int unsigned last_bv_cyc = 0;
    int unsigned last_err_cyc = 0;
    logic        mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard: pop expectations whenever the DUT reports something
    always @(negedge clk) begin
        if (mon_en) begin
            if (byte_valid) begin
                if (byte_exp_q.size() == 0) chk("byte_unexpected", int'(rx_byte), -1);
                else chk("byte", int'(rx_byte), int'(byte_exp_q.pop_front()));
                chk("byte_latency", int'(cyc), int'(fall_cyc));
                chk("byte_with_err", int'(err), 0);
                last_bv_cyc = cyc;
            end
            if (code_valid) begin
                if (code_exp_q.size() == 0) begin
                    chk("code_unexpected", int'(code), -1);
                end else begin
                    ev_t e;
                    e = code_exp_q.pop_front();
                    chk("code", int'(code), int'(e.code));
                    chk("code_break", int'(code_break), int'(e.brk));
                    chk("code_ext", int'(code_ext), int'(e.ext));
                end
                chk("code_latency", int'(cyc), int'(last_bv_cyc + 1));
            end
            if (err) begin
                if (err_exp_q.size() == 0) chk("err_unexpected", int'(err_type), -1);
                else chk("err_type", int'(err_type), int'(err_exp_q.pop_front()));
                last_err_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (3) tick();
        ps2_clk = 1'b0;
        tick();
        fall_cyc = cyc;
        repeat (3) tick();
        ps2_clk = 1'b1;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                              input int unsigned nbits);
        logic [10:0] f;
        f = {~sb, (~^d) ^ pb, d, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_byte_valid"}, int'(byte_valid), 0);
        chk({tag, "_rx_byte"},    int'(rx_byte),    0);
        chk({tag, "_code_valid"}, int'(code_valid), 0);
        chk({tag, "_code"},       int'(code),       0);
        chk({tag, "_code_break"}, int'(code_break), 0);
        chk({tag, "_code_ext"},   int'(code_ext),   0);
        chk({tag, "_err"},        int'(err),        0);
        chk({tag, "_err_type"},   int'(err_type),   0);
    endtask

    vec_t vecs[15];
    int unsigned tout_fall;

    initial begin
        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 2'b00, 1'b1, 8'h1C, 1'b0, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 2'b00, 1'b1, 8'h1C, 1'b1, 1'b0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{8'hF0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{8'h75, 1'b0, 1'b0, 2'b00, 1'b1, 8'h75, 1'b1, 1'b1};
        vecs[6]  = '{8'h1C, 1'b0, 1'b0, 2'b00, 1'b1, 8'h1C, 1'b0, 1'b0};
        vecs[7]  = '{8'h1C, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'h1C, 1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{8'hF0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{8'h1C, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{8'h1C, 1'b0, 1'b0, 2'b00, 1'b1, 8'h1C, 1'b0, 1'b0};
        vecs[12] = '{8'hE0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[13] = '{8'hE0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[14] = '{8'h5A, 1'b0, 1'b0, 2'b00, 1'b1, 8'h5A, 1'b0, 1'b1};

        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) tick();

        // Table-driven frames
        for (int unsigned i = 0; i < 15; i++) begin
            if (vecs[i].exp_err == 2'b00) byte_exp_q.push_back(vecs[i].data);
            else err_exp_q.push_back(vecs[i].exp_err);
            if (vecs[i].exp_ev)
                code_exp_q.push_back('{vecs[i].exp_code, vecs[i].exp_brk, vecs[i].exp_ext});
            send_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop_bad, 11);
            repeat (2) tick();
        end

        // Timeout: a pending break prefix, then a stalled frame
        byte_exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b0, 1'b0, 11);
        repeat (2) tick();
        err_exp_q.push_back(2'b11);
        send_frame(8'h1C, 1'b0, 1'b0, 5);
        tout_fall = fall_cyc;
        repeat (60) tick();
        chk("timeout_latency", int'(last_err_cyc - tout_fall), 49);
        chk("timeout_err_type", int'(err_type), 3);
        byte_exp_q.push_back(8'h29);
        code_exp_q.push_back('{8'h29, 1'b0, 1'b0});
        send_frame(8'h29, 1'b0, 1'b0, 11);
        repeat (3) tick();
        chk("rx_byte_hold_29", int'(rx_byte), 8'h29);

        // Mid-frame reset after an extended prefix and 5 data bits of 0xF0
        byte_exp_q.push_back(8'hE0);
        send_frame(8'hE0, 1'b0, 1'b0, 11);
        repeat (2) tick();
        send_frame(8'hF0, 1'b0, 1'b0, 6);
        rst = 1'b1;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        tick();
        // Remaining bits 5..7, parity and stop of 0xF0 are all ones
        for (int unsigned i = 0; i < 5; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (60) tick();
        byte_exp_q.push_back(8'h1C);
        code_exp_q.push_back('{8'h1C, 1'b0, 1'b0});
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        repeat (10) tick();

        chk("byte_pending", int'(byte_exp_q.size()), 0);
        chk("code_pending", int'(code_exp_q.size()), 0);
        chk("err_pending",  int'(err_exp_q.size()),  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
